piano_tone_scheduler: RTL
=========================

# piano_tone_scheduler

Sequencer and arbiter for the single square-wave tone generator of the digital piano. It steps through a song stored in an external note ROM at a fixed beat rate and shares the tone generator between song playback and the live keyboard, with the keyboard taking priority. It drives the half-period and enable inputs of the tone generator and replaces the per-song hard-coded sequencers.

## Interface
- BEAT_DIV, 1250000: clk_5MHz cycles per beat (4 Hz at 5 MHz)
- STEP_W, 8: song step counter width (max 256 steps per song)
- SONG_W, 2: song select width
- clk_5MHz  in  1  system clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- key_code  in  5  live key note index; 0 = no key, 1..21 = note
- song_sel  in  SONG_W  song to start, sampled on play
- play  in  1  single-cycle start pulse
- stop  in  1  single-cycle stop pulse
- rom_addr  out  SONG_W+STEP_W  {song, step} address to note ROM
- rom_data  in  5  note index from ROM; 1-cycle synchronous read latency
- half_period  out  16  tone generator toggle count
- tone_en  out  1  tone generator enable; 0 = silence
- playing  out  1  high in FETCH, PLAY or PAUSE

## Operation
- Note index encoding: 0 = rest, 1..7 = low 1..7, 8..14 = mid 1..7, 15..21 = high 1..7, 31 = end marker, 22..30 = treated as rest.
- Half-period lookup for 1..21: 22900, 20408, 18181, 17142, 15267, 13605, 12121, 11472, 10216, 9101, 8571, 7653, 6818, 6060, 5733, 5108, 4551, 4294, 3826, 3409, 3050.
- FSM states:
  - IDLE: play loads step=0 and song=song_sel, then moves to FETCH.
  - FETCH: waits one cycle for rom_data, latches it into cur_note, clears the beat counter, then moves to PLAY.
  - PLAY: on beat tick, step++ and moves to FETCH. If cur_note==31, moves to IDLE instead (or loops, see Configuration). key_code!=0 moves to PAUSE.
  - PAUSE: beat counter and step are frozen. key_code==0 returns to PLAY with the remaining beat count preserved.
- stop in any state moves to IDLE. stop and play in the same cycle: stop wins.
- play while playing restarts at step 0 with the new song_sel.
- Step wrap: a tick at step 2^STEP_W-1 is treated as an end marker.
- Output arbitration, registered:
  - key_code!=0: half_period=lut(key_code), tone_en=1.
  - Otherwise, if in PLAY with cur_note in 1..21: half_period=lut(cur_note), tone_en=1.
  - Otherwise tone_en=0 and half_period holds its last value.
- On a change of half_period, the tone generator counter is not reset by this block.

## Timing
- Reset values: rom_addr=0, half_period=0, tone_en=0, playing=0, state IDLE, beat counter 0, cur_note 0.
- Beat tick asserts when the beat counter == BEAT_DIV-1; the counter then wraps to 0. Each step lasts BEAT_DIV+2 cycles (FETCH plus the latch cycle).
- key_code change to outputs: 1 cycle.
- play pulse to first tone_en from the song: 3 cycles (IDLE→FETCH, ROM latency, output register).
- rom_addr is valid during FETCH and is held otherwise.
- Reset mid-song: all state is cleared immediately and asynchronously; no tone after release until the next play.

## Configuration
- PIANO_TONE_SCHED_LOOP_EN defined: end marker or step wrap sets step=0 and moves to FETCH, so the same song repeats until stop.
- PIANO_TONE_SCHED_LOOP_EN undefined: end marker or step wrap moves to IDLE, clears playing, and sets tone_en=0.

## Structure
- Shared package piano_pkg:
  - note index typedef and the constants NOTE_REST=0 and NOTE_END=31
  - the 21-entry half-period constant table
  - FSM state enum
- Sub-module piano_beat_timer: BEAT_DIV prescaler with clear and freeze inputs and a tick output.
- Note LUT: a package function, not a separate module.

## Test plan
- BEAT_DIV=4, ROM song 0 = {8, 9, 31}, play with song_sel=0 -> half_period 11472 then 10216, each for 6 cycles; then tone_en=0 and playing=0.
- Mid-song, key_code=15 for 10 cycles -> half_period=5733 and step frozen; after release, the song resumes at the same step with the remaining beat count.
- stop and play in the same cycle while playing -> IDLE, tone_en=0 next cycle.
- ROM note 25 -> tone_en=0 for that step; the step still advances.
- PIANO_TONE_SCHED_LOOP_EN defined, song {3, 31} -> 18181 repeats until stop.
- rst_n low mid-note -> all outputs 0 immediately; rom_addr=0 after release.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the piano tone scheduler.
// Note index encoding, the half-period table for the 21 playable notes,
// FSM state encoding, and the note lookup helpers.
package piano_pkg;

    typedef logic [4:0] note_t;

    localparam note_t NOTE_REST    = 5'd0;
    localparam note_t NOTE_HIGHEST = 5'd21;
    localparam note_t NOTE_END     = 5'd31;

    // Tone generator toggle counts for notes 1..21 (low 1..7, mid 1..7, high 1..7)
    localparam logic [15:0] HALF_PERIOD_TBL [0:20] = '{
        16'd22900, 16'd20408, 16'd18181, 16'd17142, 16'd15267, 16'd13605, 16'd12121,
        16'd11472, 16'd10216, 16'd9101,  16'd8571,  16'd7653,  16'd6818,  16'd6060,
        16'd5733,  16'd5108,  16'd4551,  16'd4294,  16'd3826,  16'd3409,  16'd3050
    };

    // Legacy state encodings, kept so existing probes and dumps still decode
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_PLAY  = ST_PLAY,
        S_PAUSE = ST_PAUSE
    } state_e;

    // True for indices that produce a tone; rests, 22..30 and the end marker do not
    function automatic logic note_is_tone(input note_t n);
        return (n != NOTE_REST) && (n <= NOTE_HIGHEST);
    endfunction

    // Half-period for a playable note, zero otherwise
    function automatic logic [15:0] note_half_period(input note_t n);
        if (note_is_tone(n)) begin
            return HALF_PERIOD_TBL[n - 5'd1];
        end
        return '0;
    endfunction

endpackage

// File: rtl/piano_beat_timer.sv
// piano_beat_timer: BEAT_DIV prescaler producing one tick per beat.
// clr forces the count to zero, freeze holds it; tick is suppressed
// while either is active.
module piano_beat_timer
    import piano_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 1250000
) (
    input  logic clk_5MHz,
    input  logic rst_n,
    input  logic clr,
    input  logic freeze,
    output logic tick
);

    localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = ~clr & ~freeze & (cnt == LAST);

    // Beat counter: clear, hold, or count up and wrap on the tick
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piano_tone_scheduler.sv
// piano_tone_scheduler: steps a song from the external note ROM at the beat
// rate and arbitrates the single tone generator between song playback and
// the live keyboard (keyboard wins).
// Build option: define PIANO_TONE_SCHED_LOOP_EN to repeat the song at its
// end marker / step wrap instead of returning to idle.
module piano_tone_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 1250000,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned SONG_W   = 2
) (
    input  logic                     clk_5MHz,
    input  logic                     rst_n,
    input  logic [4:0]               key_code,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     play,
    input  logic                     stop,
    output logic [SONG_W+STEP_W-1:0] rom_addr,
    input  logic [4:0]               rom_data,
    output logic [15:0]              half_period,
    output logic                     tone_en,
    output logic                     playing
);

    state_e            state, state_d;
    logic [STEP_W-1:0] step, step_d;
    logic [SONG_W-1:0] song, song_d;
    note_t             cur_note, note_d;
    logic              fetch_wait, fetch_wait_d;

    logic              beat_tick;
    logic              key_active;
    logic              end_hit;
    logic [15:0]       half_period_d;
    logic              tone_en_d;

    assign key_active = (key_code != NOTE_REST);
    assign end_hit    = (cur_note == NOTE_END) || (step == '1);
    assign rom_addr   = {song, step};
    assign playing    = (state != S_IDLE);

    piano_beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk_5MHz (clk_5MHz),
        .rst_n    (rst_n),
        .clr      (state == S_FETCH),
        .freeze   (state != S_PLAY),
        .tick     (beat_tick)
    );

    // Sequencer next-state: stop beats play, play restarts from step 0
    always_comb begin
        state_d      = state;
        step_d       = step;
        song_d       = song;
        note_d       = cur_note;
        fetch_wait_d = fetch_wait;
        if (stop) begin
            state_d = S_IDLE;
        end else if (play) begin
            song_d       = song_sel;
            step_d       = '0;
            state_d      = S_FETCH;
            fetch_wait_d = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_FETCH: begin
                    // First cycle covers the ROM read latency, second latches the note
                    if (fetch_wait) begin
                        fetch_wait_d = 1'b0;
                    end else begin
                        note_d  = rom_data;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (beat_tick) begin
                        if (end_hit) begin
`ifdef PIANO_TONE_SCHED_LOOP_EN
                            step_d       = '0;
                            state_d      = S_FETCH;
                            fetch_wait_d = 1'b1;
`else
                            state_d      = S_IDLE;
`endif
                        end else begin
                            step_d       = step + 1'b1;
                            state_d      = S_FETCH;
                            fetch_wait_d = 1'b1;
                        end
                    end else if (key_active) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!key_active) begin
                        state_d = S_PLAY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output arbitration is fed from next-state values so the registered
    // tone lines up cycle-for-cycle with the registered FSM state.
    always_comb begin
        half_period_d = half_period;
        tone_en_d     = 1'b0;
        if (key_active) begin
            tone_en_d = note_is_tone(key_code);
            if (tone_en_d) begin
                half_period_d = note_half_period(key_code);
            end
        end else if ((state_d == S_PLAY) && note_is_tone(note_d)) begin
            tone_en_d     = 1'b1;
            half_period_d = note_half_period(note_d);
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            step       <= '0;
            song       <= '0;
            cur_note   <= NOTE_REST;
            fetch_wait <= 1'b0;
        end else begin
            state      <= state_d;
            step       <= step_d;
            song       <= song_d;
            cur_note   <= note_d;
            fetch_wait <= fetch_wait_d;
        end
    end

    // Registered tone generator outputs
    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            half_period <= '0;
            tone_en     <= 1'b0;
        end else begin
            half_period <= half_period_d;
            tone_en     <= tone_en_d;
        end
    end

endmodule
